// File: rtl/fifo_buffer_pkg.sv
// Shared widths and status type for the fifo_buffer block.
package fifo_buffer_pkg;

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int level_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef struct packed {
    logic empty;
    logic full;
    logic almost_empty;
    logic almost_full;
  } fifo_status_t;

endpackage

// File: rtl/fifo_buffer_pointer.sv
// Wrap-around index counter 0..DEPTH-1; wraps explicitly so any DEPTH works.
module fifo_buffer_pointer
  import fifo_buffer_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         clear,
  input  logic                         increment,
  output logic [addr_width(DEPTH)-1:0] index
);

  localparam int AW = addr_width(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      index <= '0;
    end else if (clear) begin
      index <= '0;
    end else if (increment) begin
      index <= (index == LAST) ? '0 : index + AW'(1);
    end
  end

endmodule

// File: rtl/fifo_buffer.sv
// Synchronous FIFO with exact level, watermarks, flush and registered read port.
// Optional sticky overflow/underflow flags: define FIFO_BUFFER_ERROR_FLAGS_EN.
module fifo_buffer
  import fifo_buffer_pkg::*;
#(
  parameter int WIDTH_DATA         = 8,
  parameter int DEPTH              = 8,
  parameter int ALMOST_FULL_LEVEL  = 6,
  parameter int ALMOST_EMPTY_LEVEL = 2
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          flush,
  input  logic                          write_enable,
  input  logic [WIDTH_DATA-1:0]         write_data,
  input  logic                          read_enable,
  output logic [WIDTH_DATA-1:0]         read_data,
  output logic                          read_valid,
  output logic                          is_empty,
  output logic                          is_full,
  output logic                          is_almost_empty,
  output logic                          is_almost_full,
  output logic [level_width(DEPTH)-1:0] level
`ifdef FIFO_BUFFER_ERROR_FLAGS_EN
  ,
  output logic                          overflow,
  output logic                          underflow
`endif
);

  localparam int AW = addr_width(DEPTH);
  localparam int LW = level_width(DEPTH);

  // Handshake: a request is taken on the edge where its *_accept is high;
  // requests that are not accepted are dropped, never held. read_valid is a
  // one-cycle strobe, one cycle after each accepted read, with read_data.
  fifo_status_t          status;
  logic                  read_accept;
  logic                  write_accept;
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [WIDTH_DATA-1:0] mem [DEPTH];

  always_comb begin
    status              = '0;
    status.empty        = (level == '0);
    status.full         = (level == LW'(DEPTH));
    status.almost_empty = (level <= LW'(ALMOST_EMPTY_LEVEL));
    status.almost_full  = (level >= LW'(ALMOST_FULL_LEVEL));
  end

  assign is_empty        = status.empty;
  assign is_full         = status.full;
  assign is_almost_empty = status.almost_empty;
  assign is_almost_full  = status.almost_full;

  // A full FIFO still takes a write when a read frees a slot on the same edge.
  assign read_accept  = read_enable & ~status.empty & ~flush;
  assign write_accept = write_enable & ~flush & (~status.full | read_accept);

  fifo_buffer_pointer #(.DEPTH(DEPTH)) u_wr_ptr (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (flush),
    .increment (write_accept),
    .index     (wr_ptr)
  );

  fifo_buffer_pointer #(.DEPTH(DEPTH)) u_rd_ptr (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (flush),
    .increment (read_accept),
    .index     (rd_ptr)
  );

  // Storage is deliberately left out of reset and flush.
  always_ff @(posedge clock) begin
    if (write_accept) begin
      mem[wr_ptr] <= write_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      read_data  <= '0;
      read_valid <= 1'b0;
    end else begin
      read_valid <= read_accept;
      if (read_accept) begin
        read_data <= mem[rd_ptr];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      level <= '0;
    end else if (flush) begin
      level <= '0;
    end else if (write_accept && !read_accept) begin
      level <= level + LW'(1);
    end else if (!write_accept && read_accept) begin
      level <= level - LW'(1);
    end
  end

`ifdef FIFO_BUFFER_ERROR_FLAGS_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (write_enable && !write_accept) overflow  <= 1'b1;
      if (read_enable && status.empty)   underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/fifo_buffer.md
# fifo_buffer

Parametrised synchronous FIFO: next-generation buffer for the core's prefetch/bus paths. Supports any integer depth (not just powers of two) and an exact occupancy count, and asserts full only when every entry is used. Adds almost-full/almost-empty watermarks, a synchronous flush, a registered read-data valid strobe and optional sticky error flags. Sits between a producer (e.g. bus unit) and a consumer (e.g. instruction queue) in one clock domain.

## Interface
- WIDTH_DATA, 8, data word width (≥1)
- DEPTH, 8, number of entries (any integer ≥2)
- ALMOST_FULL_LEVEL, 6, is_almost_full when level ≥ this (1..DEPTH)
- ALMOST_EMPTY_LEVEL, 2, is_almost_empty when level ≤ this (0..DEPTH-1)

Ports:
- clock  input  1  sole clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- flush  input  1  synchronous clear; priority over read/write
- write_enable  input  1  write request
- write_data  input  WIDTH_DATA  data to store
- read_enable  input  1  read request
- read_data  output  WIDTH_DATA  registered read word
- read_valid  output  1  read_data updated this cycle
- is_empty  output  1  level == 0
- is_full  output  1  level == DEPTH
- is_almost_empty  output  1  level ≤ ALMOST_EMPTY_LEVEL
- is_almost_full  output  1  level ≥ ALMOST_FULL_LEVEL
- level  output  LEVEL_WIDTH  occupancy, LEVEL_WIDTH = $clog2(DEPTH+1)
- overflow, underflow  output  1  sticky errors (only with FIFO_BUFFER_ERROR_FLAGS_EN)

## Operation
- read_accept = read_enable & !is_empty & !flush.
- write_accept = write_enable & !flush & (!is_full | read_accept): write to a full FIFO succeeds when a read is accepted in the same cycle.
- Write to full without read: dropped, storage/pointers unchanged.
- Read from empty: ignored; read_valid stays 0; read_data holds. Simultaneous write to empty: write accepted, read ignored (no bypass).
- Pointers: ADDR_WIDTH = $clog2(DEPTH); increment, wrapping DEPTH-1 → 0 explicitly (not by overflow).
- level next = level + write_accept − read_accept; never exceeds DEPTH, never underflows.
- All status flags decode combinationally from registered level only.
- flush: pointers and level → 0, read_valid → 0; read_data holds; storage contents not cleared.

## Timing
- Reset values (async on reset_n low, held while low): read_data 0, read_valid 0, level 0, is_empty 1, is_full 0, is_almost_empty 1, is_almost_full 0, overflow/underflow 0.
- Read latency 1: read accepted in cycle N → read_data/read_valid in N+1; read_valid is a one-cycle strobe per accepted read; back-to-back reads give back-to-back valids.
- Write in cycle N readable from cycle N+1 (is_empty falls at N+1).
- Status/level update the edge after the accepted operation.
- Reset asserted mid-operation: all state lost, in-flight read_valid suppressed.

## Configuration
- FIFO_BUFFER_ERROR_FLAGS_EN defined: overflow sets on write_enable & !write_accept & !flush; underflow sets on read_enable & is_empty & !flush; both sticky until reset_n low or flush.
- Undefined: overflow/underflow ports absent; violating requests silently ignored as above.

## Structure
- Package fifo_buffer_pkg: level/address width functions (clog2 helpers for DEPTH, DEPTH+1), status struct type {empty, full, almost_empty, almost_full}.
- Sub-module fifo_buffer_pointer: parametrised wrap-around index counter (DEPTH, increment enable, synchronous clear, async reset_n), instantiated for read and write pointers.
- Storage: inferred register array inside fifo_buffer, written on write_accept, read registered on read_accept.

## Test plan
- DEPTH=5: write 0x11..0x15 → is_full=1, level=5 after 5th write; 6th write 0x16 dropped (overflow=1 if enabled); read 5 → 0x11..0x15 in order, is_empty=1.
- Wrap: DEPTH=5, 12 alternating write/read pairs 0x00..0x0B → data in order, level stays ≤1, pointers wrap past 4 without error.
- Full + simultaneous read/write: at level 5, read_enable & write_enable with 0xAA → level stays 5, 0xAA read out as 5th subsequent word.
- Empty + simultaneous read/write 0x3C: read ignored (read_valid 0, underflow=1 if enabled), level=1, next read returns 0x3C with read_valid one cycle later.
- Watermarks defaults (8/6/2): fill 0→8 → is_almost_empty deasserts at level 3, is_almost_full asserts at level 6.
- flush at level 4 with read/write requested → level 0, is_empty 1, read_valid 0, error flags cleared; reset_n pulse mid-burst → all outputs at reset values asynchronously.
